moore_seq_detect: RTL and testbench

//   Parametrised Moore-type serial pattern detector. Generalises the fixed "101" detector to
//   any PAT_W-bit pattern, with selectable overlapping or non-overlapping matching.

---
 rtl/moore_seq_detect.sv | 137 +++++++++++++
 tb/tb_moore_seq_detect.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect.sv
// Purpose: Moore serial pattern detector with a saturating match counter.
// Latency: y rises one cycle after the completing bit; the counter updates on that same edge.
// Backpressure: none. in_valid=0 stalls the FSM and counter; no ready is returned.
module moore_seq_detect #(
  parameter int              PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int SW = $clog2(PAT_W + 1);

  // A state is the matched prefix length k, so the values run from 0 (empty) to PAT_W (MATCH).
  typedef logic [SW-1:0] state_t;
  localparam state_t S0      = '0;
  localparam state_t S_MATCH = SW'(PAT_W);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
      $error("moore_seq_detect: PAT_W must be within 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("moore_seq_detect: CNT_W must be at least 1");
    end
  endgenerate

  // Pattern bit i counted in arrival order (i=0 is the first bit received).
  function automatic logic pbit(input int i);
    logic [PAT_W-1:0] sh;
    sh = PATTERN >> (PAT_W - 1 - i);
    return sh[0];
  endfunction

  // Length of the longest proper border of PATTERN. Overlapping detection resumes from here after MATCH.
  function automatic int border_len();
    int best;
    logic ok;
    best = 0;
    for (int j = 1; j < PAT_W; j++) begin
      ok = 1'b1;
      for (int m = 0; m < PAT_W; m++) begin
        if (m < j && pbit(m) != pbit(PAT_W - j + m)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  localparam int BORDER = border_len();

  // Compute the longest pattern prefix that is also a suffix of (first k pattern bits, then b).
  function automatic state_t next_len(input state_t k, input logic b);
    state_t best;
    logic   ok;
    logic   sb;
    int     pos;
    best = S0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= int'(k) + 1) begin
        ok = 1'b1;
        for (int m = 0; m < PAT_W; m++) begin
          if (m < j) begin
            pos = int'(k) + 1 - j + m;
            sb  = (pos == int'(k)) ? b : pbit(pos);
            if (sb != pbit(m)) ok = 1'b0;
          end
        end
        if (ok) best = SW'(j);
      end
    end
    return best;
  endfunction

  state_t           state, state_nxt, base;
  logic             hit;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  // Next-state: the FSM advances only on qualified bits. From MATCH it restarts at the border or at empty.
  always_comb begin
    state_nxt = state;
    base      = state;
    hit       = 1'b0;
    if (in_valid) begin
      if (state == S_MATCH) begin
        base = OVERLAP ? SW'(BORDER) : S0;
      end
      state_nxt = next_len(base, in);
      hit       = (state_nxt == S_MATCH);
    end
  end

  // Counter next value: a clear wins over the old count, and a same-edge match still counts once.
  always_comb begin
    cnt_nxt = match_cnt;
    if (clr_cnt) begin
      cnt_nxt = hit ? CNT_W'(1) : '0;
    end else if (hit && match_cnt != CNT_MAX) begin
      cnt_nxt = match_cnt + CNT_W'(1);
    end
    sat_nxt = (clr_cnt ? 1'b0 : cnt_sat) | (cnt_nxt == CNT_MAX);
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // Match counter and sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
      cnt_sat   <= 1'b0;
    end else begin
      match_cnt <= cnt_nxt;
      cnt_sat   <= sat_nxt;
    end
  end

  assign y = (state == S_MATCH);

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: four configurations share one input stream.
// Each configuration is checked against a sliding-window reference model.
// Fixed vector tables and hand-written sequences cover the documented scenarios.
module tb_moore_seq_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic clr_cnt = 1'b0;

  logic       y_a, y_b, y_c, y_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;
  logic       sat_a, sat_b, sat_c, sat_d;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // a: 101 overlap, b: 101 non-overlap, c: 1101 overlap, d: 101 overlap with a 2-bit counter
  moore_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .clr_cnt(clr_cnt),
    .y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a));
  moore_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .clr_cnt(clr_cnt),
    .y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b));
  moore_seq_detect #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .clr_cnt(clr_cnt),
    .y(y_c), .match_cnt(cnt_c), .cnt_sat(sat_c));
  moore_seq_detect #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .clr_cnt(clr_cnt),
    .y(y_d), .match_cnt(cnt_d), .cnt_sat(sat_d));

  // Reference model: keep a window of recent valid bits and compare its tail with the pattern.
  int          m_patw[4] = '{3, 3, 4, 3};
  int          m_pat[4]  = '{5, 5, 13, 5};
  int          m_ovl[4]  = '{1, 0, 1, 1};
  int          m_max[4]  = '{255, 255, 255, 3};
  logic [31:0] m_hist[4];
  int          m_len[4];
  int          m_y[4];
  int          m_cnt[4];
  int          m_sat[4];

  typedef struct {
    logic v;
    logic b;
    int   ya;
    int   ca;
    int   yb;
    int   cb;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = '0;
      m_len[i]  = 0;
      m_y[i]    = 0;
      m_cnt[i]  = 0;
      m_sat[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int hit;
      int mask;
      hit = 0;
      if (in_valid) begin
        if (m_ovl[i] == 0 && m_y[i] == 1) begin
          m_hist[i] = '0;
          m_len[i]  = 0;
        end
        m_hist[i] = {m_hist[i][30:0], in_bit};
        if (m_len[i] < 32) m_len[i]++;
        mask = (1 << m_patw[i]) - 1;
        hit = (m_len[i] >= m_patw[i] && (int'(m_hist[i]) & mask) == m_pat[i]) ? 1 : 0;
        m_y[i] = hit;
      end
      if (clr_cnt) begin
        m_cnt[i] = hit;
        m_sat[i] = 0;
      end else if (hit == 1 && m_cnt[i] < m_max[i]) begin
        m_cnt[i]++;
      end
      if (m_cnt[i] == m_max[i]) m_sat[i] = 1;
    end
  endtask

  function automatic int dut_y(input int i);
    case (i)
      0: return int'(y_a);
      1: return int'(y_b);
      2: return int'(y_c);
      default: return int'(y_d);
    endcase
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      2: return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  function automatic int dut_sat(input int i);
    case (i)
      0: return int'(sat_a);
      1: return int'(sat_b);
      2: return int'(sat_c);
      default: return int'(sat_d);
    endcase
  endfunction

  task automatic check_model(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s dut%0d y", tag, i), dut_y(i), m_y[i]);
      chk($sformatf("%s dut%0d cnt", tag, i), dut_cnt(i), m_cnt[i]);
      chk($sformatf("%s dut%0d sat", tag, i), dut_sat(i), m_sat[i]);
    end
  endtask

  // Drive at the falling edge, let the rising edge act, then compare at the next falling edge.
  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model("mdl");
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    model_reset();
    check_model("rst");
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic t3_bits[7] = '{1, 1, 0, 1, 1, 0, 1};
    int   t3_y[7]    = '{0, 0, 0, 1, 0, 0, 1};
    logic t5_bits[9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
    int   t5_cnt[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
    int   t5_sat[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    logic t6_bits[3] = '{1, 0, 1};
    int   t6_y[3]    = '{0, 0, 1};

    // stream 1,0,1,0,1,1,0,1 with 1-3 cycle gaps; gap bits are the inverse of neutral to prove they are ignored
    tbl[0]  = '{1'b1, 1'b1, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1, 1, 1, 1};
    tbl[6]  = '{1'b0, 1'b0, 1, 1, 1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1, 1, 1, 1};
    tbl[8]  = '{1'b0, 1'b0, 1, 1, 1, 1};
    tbl[9]  = '{1'b1, 1'b0, 0, 1, 0, 1};
    tbl[10] = '{1'b1, 1'b1, 1, 2, 0, 1};
    tbl[11] = '{1'b0, 1'b0, 1, 2, 0, 1};
    tbl[12] = '{1'b1, 1'b1, 0, 2, 0, 1};
    tbl[13] = '{1'b1, 1'b0, 0, 2, 0, 1};
    tbl[14] = '{1'b0, 1'b1, 0, 2, 0, 1};
    tbl[15] = '{1'b1, 1'b1, 1, 3, 1, 2};
    tbl[16] = '{1'b0, 1'b0, 1, 3, 1, 2};

    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // Scenarios 1 and 2: valid rows only, checking overlap (a) and non-overlap (b)
    for (int r = 0; r < 17; r++) begin
      if (tbl[r].v) begin
        step(1'b1, tbl[r].b, 1'b0);
        chk($sformatf("t1 row%0d ya", r), int'(y_a), tbl[r].ya);
        chk($sformatf("t1 row%0d ca", r), int'(cnt_a), tbl[r].ca);
        chk($sformatf("t2 row%0d yb", r), int'(y_b), tbl[r].yb);
        chk($sformatf("t2 row%0d cb", r), int'(cnt_b), tbl[r].cb);
      end
    end

    // Scenario 4: the same stream including the gap rows
    do_reset();
    for (int r = 0; r < 17; r++) begin
      step(tbl[r].v, tbl[r].b, 1'b0);
      chk($sformatf("t4 row%0d ya", r), int'(y_a), tbl[r].ya);
      chk($sformatf("t4 row%0d ca", r), int'(cnt_a), tbl[r].ca);
      chk($sformatf("t4 row%0d yb", r), int'(y_b), tbl[r].yb);
      chk($sformatf("t4 row%0d cb", r), int'(cnt_b), tbl[r].cb);
    end

    // Scenario 3: four-bit pattern 1101 with overlap
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, t3_bits[i], 1'b0);
      chk($sformatf("t3 bit%0d yc", i), int'(y_c), t3_y[i]);
    end
    chk("t3 cnt_c", int'(cnt_c), 2);

    // Scenario 5: 2-bit counter saturation, then a clear coinciding with a new match
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, t5_bits[i], 1'b0);
      chk($sformatf("t5 bit%0d cnt_d", i), int'(cnt_d), t5_cnt[i]);
      chk($sformatf("t5 bit%0d sat_d", i), int'(sat_d), t5_sat[i]);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("t5 clr+hit cnt_d", int'(cnt_d), 1);
    chk("t5 clr+hit sat_d", int'(sat_d), 0);
    chk("t5 clr+hit y_d", int'(y_d), 1);
    chk("t5 clr+hit cnt_a", int'(cnt_a), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("t5 clr only cnt_d", int'(cnt_d), 0);
    chk("t5 clr only y_d", int'(y_d), 1);

    // Scenario 6: asynchronous reset mid-cycle after bits 1,0 while counts are non-zero
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("t6 pre cnt_a", int'(cnt_a), 1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t6 async y_a", int'(y_a), 0);
    chk("t6 async cnt_a", int'(cnt_a), 0);
    chk("t6 async cnt_d", int'(cnt_d), 0);
    chk("t6 async sat_d", int'(sat_d), 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    check_model("t6 post");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, t6_bits[i], 1'b0);
      chk($sformatf("t6 bit%0d ya", i), int'(y_a), t6_y[i]);
    end
    chk("t6 cnt_a", int'(cnt_a), 1);

    // Random stream against the model: sparse valids, occasional clears and resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
